// File: rtl/div_pkg.sv
// Shared widths and FSM state type for the sequential non-restoring divider.
package div_pkg;

  localparam int unsigned N  = 20;
  localparam int unsigned D  = 10;
  localparam int unsigned PW = D + 2;
  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_addsub.sv
// Partial-remainder adder/subtractor, shared by the iteration steps and the final correction.
module div_addsub
  import div_pkg::*;
(
  input  logic [PW-1:0] a,
  input  logic [PW-1:0] b,
  input  logic          sub,
  output logic [PW-1:0] y
);

  assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/seq_divider.sv
// Radix-2 non-restoring unsigned divider: one operation in flight, valid/ready on both sides.
module seq_divider
  import div_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [D-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [D-1:0] remainder,
  output logic         div_by_zero
);

  div_state_t    state, next_state;
  logic [PW-1:0] p;
  logic [N-1:0]  q;
  logic [D-1:0]  dv;
  logic [CW-1:0] cnt;

  logic [PW-1:0] as_a, as_b, as_y;
  logic          as_sub;

  // The shared adder sees the shifted remainder while iterating and the raw remainder during the fix-up.
  always_comb begin
    as_a   = {p[PW-2:0], q[N-1]};
    as_sub = ~p[PW-1];
    if (state == FIX) begin
      as_a   = p;
      as_sub = 1'b0;
    end
  end

  assign as_b = {2'b00, dv};

  div_addsub u_addsub (
    .a   (as_a),
    .b   (as_b),
    .sub (as_sub),
    .y   (as_y)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (in_valid) next_state = (divisor == '0) ? DONE : BUSY;
      BUSY: if (cnt == '0) next_state = FIX;
      FIX:  next_state = DONE;
      DONE: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Datapath and result registers; results are only rewritten when a new result is produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      p           <= '0;
      q           <= '0;
      dv          <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend[D-1:0];
              div_by_zero <= 1'b1;
            end else begin
              dv  <= divisor;
              q   <= dividend;
              p   <= '0;
              cnt <= CW'(N - 1);
            end
          end
        end
        BUSY: begin
          p <= as_y;
          q <= {q[N-2:0], ~as_y[PW-1]};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          quotient    <= q;
          remainder   <= p[PW-1] ? as_y[D-1:0] : p[D-1:0];
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
